// File: rtl/i2s_pkg.sv
// Shared constants for the I2S transmitter: sample/frame geometry and the
// slot indices that mark the lrck edges and the holding-register transfer.
package i2s_pkg;
    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned FRAME_SLOTS = 32;
    localparam int unsigned SLOT_W      = $clog2(FRAME_SLOTS);
    localparam int unsigned FRAME_W     = 2 * SAMPLE_W;

    localparam logic [SLOT_W-1:0] SLOT_RIGHT_START = SLOT_W'(16);
    localparam logic [SLOT_W-1:0] SLOT_XFER        = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_RESET       = SLOT_W'(FRAME_SLOTS - 1);
endpackage

// File: rtl/i2s_tx_clkgen.sv
// Bit-clock generator: bck toggles every CLK_DIV clk cycles; o_fall is high
// in the clk cycle whose closing edge drives bck from 1 to 0.
module i2s_tx_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic o_bck,
    output logic o_fall
);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_div;
    logic       r_bck;
    logic       w_wrap;

    assign w_wrap = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_bck <= 1'b0;
        end else if (w_wrap) begin
            r_div <= '0;
            r_bck <= ~r_bck;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

    assign o_bck  = r_bck;
    assign o_fall = w_wrap & r_bck;
endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter (16-bit stereo, 32-slot frame, one-bit delay).
// Define I2S_TX_UNDERRUN_MUTE_EN to send silence instead of repeating on underrun.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                bck,
    output logic                lrck,
    output logic                data,
    output logic                underrun
);
    logic               w_bck;
    logic               w_fall;
    logic               w_xfer;
    logic [SLOT_W-1:0]  r_slot;
    logic [SLOT_W-1:0]  w_slot_next;
    logic               r_lrck;
    logic               r_underrun;
    logic               r_hold_valid;
    logic [FRAME_W-1:0] r_hold;
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] w_refill;

    i2s_tx_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk    (clk),
        .reset  (reset),
        .o_bck  (w_bck),
        .o_fall (w_fall)
    );

    assign w_slot_next = r_slot + SLOT_W'(1);
    assign w_xfer      = w_fall && (w_slot_next == SLOT_XFER);

`ifdef I2S_TX_UNDERRUN_MUTE_EN
    assign w_refill = '0;
`else
    logic [FRAME_W-1:0] r_last;

    always_ff @(posedge clk) begin
        if (reset)
            r_last <= '0;
        else if (w_xfer && r_hold_valid)
            r_last <= r_hold;
    end

    assign w_refill = r_last;
`endif

    // Shift MSB drives data, so the word loaded entering slot 1 ends with R[0] in slot 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot       <= SLOT_RESET;
            r_lrck       <= 1'b0;
            r_underrun   <= 1'b0;
            r_shift      <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_underrun <= w_xfer && !r_hold_valid;
            if (w_fall) begin
                r_slot <= w_slot_next;
                r_lrck <= (w_slot_next >= SLOT_RIGHT_START);
                if (w_xfer)
                    r_shift <= r_hold_valid ? r_hold : w_refill;
                else
                    r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
            end
            if (w_xfer)
                r_hold_valid <= 1'b0;
            if (in_valid && !r_hold_valid) begin
                r_hold       <= {in_left, in_right};
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign in_ready = !r_hold_valid;
    assign bck      = w_bck;
    assign lrck     = r_lrck;
    assign data     = r_shift[FRAME_W-1];
    assign underrun = r_underrun;
endmodule
